// File: rtl/vga_cursor_pos_ctrl.sv
// Cursor position controller for the VGA text controller.
// Sequences host cursor commands, keeps the linear cursor address as a
// row base plus column (no multiplier), converts absolute SET addresses
// to row/column by repeated subtraction, requests a one-row scroll when
// the cursor runs off the bottom row and generates the cursor blink phase.
module vga_cursor_pos_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 25,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [2:0]  i_cmd,
  input  logic [10:0] i_cmd_addr,
  output logic [10:0] o_cur_pos_addr,
  output logic [6:0]  o_cur_col,
  output logic [4:0]  o_cur_row,
  output logic        o_cmd_err_h,
  output logic        o_scroll_req,
  input  logic        i_scroll_ack,
  input  logic        i_frame_tick,
  output logic        o_cur_blink_h
);

  localparam logic [2:0]  CMD_NOP     = 3'd0;
  localparam logic [2:0]  CMD_ADVANCE = 3'd1;
  localparam logic [2:0]  CMD_CR      = 3'd2;
  localparam logic [2:0]  CMD_LF      = 3'd3;
  localparam logic [2:0]  CMD_BS      = 3'd4;
  localparam logic [2:0]  CMD_HOME    = 3'd5;
  localparam logic [2:0]  CMD_SET     = 3'd6;
  localparam logic [2:0]  CMD_NEWLINE = 3'd7;

  localparam logic [6:0]  LAST_COL    = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW    = 5'(ROWS - 1);
  localparam logic [10:0] COLS_W      = 11'(COLS);
  localparam logic [11:0] CELLS       = 12'(COLS * ROWS);
  localparam logic [7:0]  BLINK_LIMIT = 8'(BLINK_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    SCROLL_WAIT
  } state_e;

  state_e      state_q;
  logic        ready_q;
  logic [6:0]  col_q;
  logic [4:0]  row_q;
  logic [10:0] rowBase_q;
  logic [10:0] pos_q;
  logic        err_q;
  logic        scroll_q;
  logic [10:0] rem_q;
  logic [4:0]  divRow_q;
  logic [10:0] divBase_q;
  logic [10:0] target_q;
  logic [7:0]  blinkCnt_q;
  logic [7:0]  blinkCnt_d;
  logic        blink_q;
  logic        blink_d;
  logic        accept;

  assign accept         = i_cmd_valid & ready_q;
  assign o_cmd_ready    = ready_q;
  assign o_cur_pos_addr = pos_q;
  assign o_cur_col      = col_q;
  assign o_cur_row      = row_q;
  assign o_cmd_err_h    = err_q;
  assign o_scroll_req   = scroll_q;
  assign o_cur_blink_h  = blink_q;

  // Command sequencer: updates position, runs the SET divider and holds the scroll handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      col_q     <= '0;
      row_q     <= '0;
      rowBase_q <= '0;
      pos_q     <= '0;
      err_q     <= 1'b0;
      scroll_q  <= 1'b0;
      rem_q     <= '0;
      divRow_q  <= '0;
      divBase_q <= '0;
      target_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (i_cmd)
              CMD_ADVANCE: begin
                if (col_q == LAST_COL) begin
                  col_q <= '0;
                  if (row_q == LAST_ROW) begin
                    pos_q    <= rowBase_q;
                    state_q  <= SCROLL_WAIT;
                    ready_q  <= 1'b0;
                    scroll_q <= 1'b1;
                  end else begin
                    row_q     <= row_q + 5'd1;
                    rowBase_q <= rowBase_q + COLS_W;
                    pos_q     <= pos_q + 11'd1;
                  end
                end else begin
                  col_q <= col_q + 7'd1;
                  pos_q <= pos_q + 11'd1;
                end
              end
              CMD_CR: begin
                col_q <= '0;
                pos_q <= rowBase_q;
              end
              CMD_LF: begin
                if (row_q == LAST_ROW) begin
                  state_q  <= SCROLL_WAIT;
                  ready_q  <= 1'b0;
                  scroll_q <= 1'b1;
                end else begin
                  row_q     <= row_q + 5'd1;
                  rowBase_q <= rowBase_q + COLS_W;
                  pos_q     <= pos_q + COLS_W;
                end
              end
              CMD_NEWLINE: begin
                col_q <= '0;
                if (row_q == LAST_ROW) begin
                  pos_q    <= rowBase_q;
                  state_q  <= SCROLL_WAIT;
                  ready_q  <= 1'b0;
                  scroll_q <= 1'b1;
                end else begin
                  row_q     <= row_q + 5'd1;
                  rowBase_q <= rowBase_q + COLS_W;
                  pos_q     <= rowBase_q + COLS_W;
                end
              end
              CMD_BS: begin
                if (col_q != '0) begin
                  col_q <= col_q - 7'd1;
                  pos_q <= pos_q - 11'd1;
                end else if (row_q != '0) begin
                  col_q     <= LAST_COL;
                  row_q     <= row_q - 5'd1;
                  rowBase_q <= rowBase_q - COLS_W;
                  pos_q     <= pos_q - 11'd1;
                end
              end
              CMD_HOME: begin
                col_q     <= '0;
                row_q     <= '0;
                rowBase_q <= '0;
                pos_q     <= '0;
              end
              CMD_SET: begin
                if ({1'b0, i_cmd_addr} >= CELLS) begin
                  err_q <= 1'b1;
                end else begin
                  state_q   <= DIVIDE;
                  ready_q   <= 1'b0;
                  rem_q     <= i_cmd_addr;
                  divRow_q  <= '0;
                  divBase_q <= '0;
                  target_q  <= i_cmd_addr;
                end
              end
              CMD_NOP: begin
              end
              default: begin
              end
            endcase
          end
        end
        DIVIDE: begin
          if (rem_q >= COLS_W) begin
            rem_q     <= rem_q - COLS_W;
            divRow_q  <= divRow_q + 5'd1;
            divBase_q <= divBase_q + COLS_W;
          end else begin
            col_q     <= rem_q[6:0];
            row_q     <= divRow_q;
            rowBase_q <= divBase_q;
            pos_q     <= target_q;
            state_q   <= IDLE;
            ready_q   <= 1'b1;
          end
        end
        SCROLL_WAIT: begin
          if (i_scroll_ack) begin
            scroll_q <= 1'b0;
            state_q  <= IDLE;
            ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Blink next state: an accepted command restarts the visible phase and beats a coincident frame tick.
  always_comb begin
    blinkCnt_d = blinkCnt_q;
    blink_d    = blink_q;
    if (accept) begin
      blinkCnt_d = '0;
      blink_d    = 1'b1;
    end else if (i_frame_tick) begin
      if (blinkCnt_q + 8'd1 == BLINK_LIMIT) begin
        blinkCnt_d = '0;
        blink_d    = ~blink_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 8'd1;
      end
    end
  end

  // Blink phase registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blinkCnt_q <= '0;
      blink_q    <= 1'b1;
    end else begin
      blinkCnt_q <= blinkCnt_d;
      blink_q    <= blink_d;
    end
  end

endmodule

// File: tb/tb_vga_cursor_pos_ctrl.sv
// Self-checking bench for vga_cursor_pos_ctrl: directed scenarios followed by
// random command traffic, all compared against a linear-address reference model.
module tb_vga_cursor_pos_ctrl;

  localparam int COLS         = 80;
  localparam int ROWS         = 25;
  localparam int BLINK_FRAMES = 16;
  localparam int CELLS        = COLS * ROWS;

  localparam int C_NOP     = 0;
  localparam int C_ADVANCE = 1;
  localparam int C_CR      = 2;
  localparam int C_LF      = 3;
  localparam int C_BS      = 4;
  localparam int C_HOME    = 5;
  localparam int C_SET     = 6;
  localparam int C_NEWLINE = 7;

  localparam int M_IDLE   = 0;
  localparam int M_DIVIDE = 1;
  localparam int M_SCROLL = 2;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [2:0]  i_cmd;
  logic [10:0] i_cmd_addr;
  logic [10:0] o_cur_pos_addr;
  logic [6:0]  o_cur_col;
  logic [4:0]  o_cur_row;
  logic        o_cmd_err_h;
  logic        o_scroll_req;
  logic        i_scroll_ack;
  logic        i_frame_tick;
  logic        o_cur_blink_h;

  int checks = 0;
  int errors = 0;

  // reference model state, expressed as a linear cell index
  int mPos;
  int mMode;
  int mLeft;
  int mTarget;
  int mCnt;
  int mReady;
  int mErr;
  int mScroll;
  int mBlink;

  vga_cursor_pos_ctrl #(
    .COLS(COLS),
    .ROWS(ROWS),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd(i_cmd),
    .i_cmd_addr(i_cmd_addr),
    .o_cur_pos_addr(o_cur_pos_addr),
    .o_cur_col(o_cur_col),
    .o_cur_row(o_cur_row),
    .o_cmd_err_h(o_cmd_err_h),
    .o_scroll_req(o_scroll_req),
    .i_scroll_ack(i_scroll_ack),
    .i_frame_tick(i_frame_tick),
    .o_cur_blink_h(o_cur_blink_h)
  );

  // free-running clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("pos", int'(o_cur_pos_addr), mPos);
    checkOutput("col", int'(o_cur_col), mPos % COLS);
    checkOutput("row", int'(o_cur_row), mPos / COLS);
    checkOutput("ready", int'(o_cmd_ready), mReady);
    checkOutput("err", int'(o_cmd_err_h), mErr);
    checkOutput("scroll_req", int'(o_scroll_req), mScroll);
    checkOutput("blink", int'(o_cur_blink_h), mBlink);
  endtask

  task automatic modelReset();
    mPos    = 0;
    mMode   = M_IDLE;
    mLeft   = 0;
    mTarget = 0;
    mCnt    = 0;
    mReady  = 1;
    mErr    = 0;
    mScroll = 0;
    mBlink  = 1;
  endtask

  task automatic startScroll();
    mMode   = M_SCROLL;
    mReady  = 0;
    mScroll = 1;
  endtask

  task automatic lineFeed();
    if (mPos / COLS == ROWS - 1) startScroll();
    else mPos = mPos + COLS;
  endtask

  // advances the model by one clock edge using the inputs currently driven
  task automatic modelStep();
    int accepted;
    int addr;
    accepted = (i_cmd_valid == 1'b1 && mReady == 1) ? 1 : 0;
    addr = int'(i_cmd_addr);
    mErr = 0;
    if (accepted == 1) begin
      mCnt  = 0;
      mBlink = 1;
    end else if (i_frame_tick == 1'b1) begin
      mCnt++;
      if (mCnt == BLINK_FRAMES) begin
        mCnt = 0;
        mBlink = 1 - mBlink;
      end
    end
    if (mMode == M_DIVIDE) begin
      mLeft--;
      if (mLeft == 0) begin
        mPos   = mTarget;
        mMode  = M_IDLE;
        mReady = 1;
      end
    end else if (mMode == M_SCROLL) begin
      if (i_scroll_ack == 1'b1) begin
        mScroll = 0;
        mMode   = M_IDLE;
        mReady  = 1;
      end
    end else if (accepted == 1) begin
      case (int'(i_cmd))
        C_ADVANCE: begin
          if (mPos == CELLS - 1) begin
            mPos = (ROWS - 1) * COLS;
            startScroll();
          end else begin
            mPos++;
          end
        end
        C_CR:      mPos = mPos - (mPos % COLS);
        C_LF:      lineFeed();
        C_NEWLINE: begin
          mPos = mPos - (mPos % COLS);
          lineFeed();
        end
        C_BS:      if (mPos > 0) mPos--;
        C_HOME:    mPos = 0;
        C_SET: begin
          if (addr >= CELLS) begin
            mErr = 1;
          end else begin
            mMode   = M_DIVIDE;
            mLeft   = addr / COLS + 1;
            mTarget = addr;
            mReady  = 0;
          end
        end
        default: begin
        end
      endcase
    end
  endtask

  // drive one cycle of inputs at a falling edge, step the model, check outputs at the next falling edge
  task automatic applyStimulus(input int valid, input int cmd, input int addr, input int ack, input int tick);
    i_cmd_valid  = valid[0];
    i_cmd        = cmd[2:0];
    i_cmd_addr   = addr[10:0];
    i_scroll_ack = ack[0];
    i_frame_tick = tick[0];
    @(posedge i_clk);
    modelStep();
    @(negedge i_clk);
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, C_NOP, 0, 0, 0);
  endtask

  task automatic setAndWait(input int addr);
    applyStimulus(1, C_SET, addr, 0, 0);
    idleCycles(addr / COLS + 1);
  endtask

  // asserts reset between clock edges and checks that outputs clear without waiting for a clock
  task automatic asyncReset();
    i_cmd_valid  = 1'b0;
    i_scroll_ack = 1'b0;
    i_frame_tick = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    @(negedge i_clk);
    compareAll();
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n      = 1'b1;
    i_cmd_valid  = 1'b0;
    i_cmd        = 3'd0;
    i_cmd_addr   = 11'd0;
    i_scroll_ack = 1'b0;
    i_frame_tick = 1'b0;
    modelReset();
    #1 i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    compareAll();
    i_rst_n = 1'b1;

    $display("[TB] back-to-back advance across a row boundary");
    for (int k = 0; k < 81; k++) applyStimulus(1, C_ADVANCE, 0, 0, 0);
    checkOutput("adv81_pos", int'(o_cur_pos_addr), 81);

    $display("[TB] set to last cell, advance into scroll");
    setAndWait(1999);
    checkOutput("set1999_col", int'(o_cur_col), 79);
    applyStimulus(1, C_ADVANCE, 0, 0, 0);
    idleCycles(4);
    applyStimulus(0, C_NOP, 0, 1, 0);
    checkOutput("scroll_done_pos", int'(o_cur_pos_addr), 1920);

    $display("[TB] out-of-range set");
    applyStimulus(1, C_SET, 2000, 0, 0);
    idleCycles(2);
    applyStimulus(1, C_SET, 2047, 0, 0);

    $display("[TB] backspace and line feed edges");
    applyStimulus(1, C_HOME, 0, 0, 0);
    applyStimulus(1, C_BS, 0, 0, 0);
    setAndWait(3 * COLS);
    applyStimulus(1, C_BS, 0, 0, 0);
    checkOutput("bs_wrap_pos", int'(o_cur_pos_addr), 239);
    setAndWait(24 * COLS + 10);
    applyStimulus(1, C_LF, 0, 0, 0);
    idleCycles(2);
    applyStimulus(0, C_NOP, 0, 1, 0);
    applyStimulus(1, C_NEWLINE, 0, 0, 0);
    applyStimulus(0, C_NOP, 0, 1, 0);
    applyStimulus(1, C_CR, 0, 0, 0);
    setAndWait(5 * COLS + 7);
    applyStimulus(1, C_NEWLINE, 0, 0, 0);
    applyStimulus(1, C_LF, 0, 0, 0);

    $display("[TB] blink phase");
    for (int k = 0; k < 2 * BLINK_FRAMES; k++) applyStimulus(0, C_NOP, 0, 0, 1);
    for (int k = 0; k < BLINK_FRAMES - 1; k++) applyStimulus(0, C_NOP, 0, 0, 1);
    applyStimulus(1, C_NOP, 0, 0, 1);
    for (int k = 0; k < BLINK_FRAMES; k++) applyStimulus(0, C_NOP, 0, 0, 1);

    $display("[TB] reset during scroll wait and divide");
    setAndWait(1999);
    applyStimulus(1, C_ADVANCE, 0, 0, 0);
    applyStimulus(0, C_NOP, 0, 0, 0);
    asyncReset();
    applyStimulus(0, C_NOP, 0, 1, 0);
    applyStimulus(1, C_SET, 1999, 0, 0);
    idleCycles(3);
    asyncReset();
    idleCycles(2);
    applyStimulus(0, C_NOP, 0, 1, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      int v;
      int c;
      int a;
      int ack;
      int tick;
      v    = ($urandom_range(0, 9) < 7) ? 1 : 0;
      c    = int'($urandom_range(0, 7));
      a    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(CELLS, 2047))
                                         : int'($urandom_range(0, CELLS - 1));
      ack  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      tick = ($urandom_range(0, 2) == 0) ? 1 : 0;
      applyStimulus(v, c, a, ack, tick);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_cursor_pos_ctrl.md
# vga_cursor_pos_ctrl

Cursor position controller for the VGA text controller. Sequences host cursor commands (advance, CR, LF, backspace, home, absolute set) and maintains the linear cursor address consumed by the cursor-coordinate comparator in the character output path. Requests a screen scroll from the text-RAM scroller when the cursor leaves the bottom row, and generates the cursor blink phase from frame ticks.

## Interface
Parameters:
- COLS, 80, characters per row (2..128)
- ROWS, 25, rows per screen (2..32); COLS*ROWS <= 2048
- BLINK_FRAMES, 16, frame ticks per blink half-period (1..255)

Ports:
- i_clk  in  1  system clock; single clock domain
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  controller can accept a command
- i_cmd  in  3  0 NOP, 1 ADVANCE, 2 CR, 3 LF, 4 BS, 5 HOME, 6 SET, 7 NEWLINE (CR+LF)
- i_cmd_addr  in  11  linear target address for SET
- o_cur_pos_addr  out  11  linear cursor address = row*COLS + col
- o_cur_col  out  7  cursor column
- o_cur_row  out  5  cursor row
- o_cmd_err_h  out  1  one-cycle pulse: SET address out of range
- o_scroll_req  out  1  scroll-up-one-row request, level
- i_scroll_ack  in  1  scroller done, one-cycle pulse
- i_frame_tick  in  1  one-cycle pulse per frame (vsync)
- o_cur_blink_h  out  1  cursor visible phase

## Operation
- States: IDLE, DIVIDE, SCROLL_WAIT. o_cmd_ready = 1 only in IDLE (registered).
- Command accepted on rising edge with i_cmd_valid & o_cmd_ready. NOP accepted, no effect except blink restart.
- Address maintained incrementally (row base register + col); no multiplier.
- ADVANCE: col+1; at col COLS-1 -> col 0, row+1; at last row -> row stays ROWS-1, col 0, go SCROLL_WAIT.
- CR: col 0. HOME: col 0, row 0.
- LF: row+1, col unchanged; at row ROWS-1 -> row unchanged, go SCROLL_WAIT.
- NEWLINE: col 0 plus LF rules.
- BS: col-1; at col 0, row>0 -> col COLS-1, row-1; at (0,0) no change, no error.
- SET: if i_cmd_addr >= COLS*ROWS -> position unchanged, o_cmd_err_h pulses next cycle, stay IDLE. Else go DIVIDE: rem=addr, row=0; each cycle rem>=COLS -> rem-=COLS, row+1; else col=rem, pos=addr, -> IDLE. Outputs hold old position until DIVIDE completes (all three update together).
- SCROLL_WAIT: o_scroll_req=1 (set on entry edge) until i_scroll_ack sampled high; then req 0 and -> IDLE same edge. Cursor position already final on entry. i_scroll_ack outside SCROLL_WAIT ignored.
- Blink: 8-bit counter of i_frame_tick; at BLINK_FRAMES ticks toggle o_cur_blink_h, clear counter. Any accepted command clears counter and forces o_cur_blink_h=1; this wins over a coincident i_frame_tick.

## Timing
- Reset values: o_cur_pos_addr 0, o_cur_col 0, o_cur_row 0, o_cmd_ready 1, o_cmd_err_h 0, o_scroll_req 0, o_cur_blink_h 1, state IDLE, blink counter 0.
- Reset asserted mid-DIVIDE or mid-SCROLL_WAIT: immediate return to reset values; pending scroll dropped.
- ADVANCE/CR/LF/BS/HOME/NEWLINE/NOP: new position visible 1 cycle after accept edge; next command accepted the following edge (back-to-back, 1 command/cycle).
- SET in range: ready low for row_target+1 cycles; new position visible on the edge that returns to IDLE.
- Scroll: o_scroll_req high 1 cycle after accept; ready returns 1 the cycle after i_scroll_ack.
- Blink toggles on the edge sampling the BLINK_FRAMES-th tick.

## Test plan
- Reset then 81 ADVANCE (COLS=80) back-to-back -> pos 81, col 1, row 1; ready never drops.
- SET 1999 -> ready low 25 cycles, then pos 1999, col 79, row 24; ADVANCE -> col 0, row 24, pos 1920, scroll_req until ack 5 cycles later, ready returns next cycle.
- SET 2000 -> err pulse 1 cycle, position unchanged, ready stays 1.
- At (0,0) BS -> no change; at (0,3) BS -> col 79, row 2, pos 239; LF at row 24 col 10 -> scroll_req, col 10 kept.
- 16 frame ticks idle -> blink 1->0; 16 more -> 1; command coincident with 16th tick -> blink stays 1, counter 0.
- Assert i_rst_n low during SCROLL_WAIT and during DIVIDE -> all outputs at reset values asynchronously; late i_scroll_ack ignored.
